// File: rtl/x64_bc_pkg.sv
// Shared types and constants for the div64 result byte serializer.
// Build option: define BC_CHECKSUM_EN to append an XOR checksum byte to every frame.
package x64_bc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDone
    } state_t;

    localparam int unsigned OP_W   = 64;
    localparam int unsigned BYTE_W = 8;

`ifdef BC_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = 17;
    localparam int unsigned CNT_W       = 5;
`else
    localparam int unsigned FRAME_BYTES = 16;
    localparam int unsigned CNT_W       = 4;
`endif

endpackage

// File: rtl/x64_bc_rr_arb.sv
// Combinational round-robin arbiter: searches upward from last_grant+1, wrapping at NREQ.
module x64_bc_rr_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic            gnt_valid,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx
);

    always_comb begin
        int unsigned idx;
        gnt_valid  = 1'b0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        idx        = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            // last_grant < NREQ, so one subtraction is enough to wrap
            idx = 32'(last_grant) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!gnt_valid && (j == idx) && req[j]) begin
                    gnt_valid     = 1'b1;
                    gnt_onehot[j] = 1'b1;
                    gnt_idx       = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/x64_bc_sched.sv
// Round-robin arbiter and 128-bit to byte serializer for the div64 result stream.
// Build option: define BC_CHECKSUM_EN to append an XOR checksum byte to every frame.
module x64_bc_sched
    import x64_bc_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [OP_W*NREQ-1:0] data_a,
    input  logic [OP_W*NREQ-1:0] data_b,
    output logic [NREQ-1:0]      ack,
    output logic [BYTE_W-1:0]    byte_o,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 byte_last,
    output logic [IDW-1:0]       src_id,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned SHIFT_W = 2 * OP_W;

    state_t               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;
    logic [IDW-1:0]       src_id_q, src_id_d;
    logic [NREQ-1:0]      ack_q, ack_d;
`ifdef BC_CHECKSUM_EN
    logic [BYTE_W-1:0]    csum_q, csum_d;
`endif

    logic                 gnt_valid;
    logic [NREQ-1:0]      gnt_onehot;
    logic [IDW-1:0]       gnt_idx;
    logic [OP_W-1:0]      sel_a, sel_b;
    logic                 is_last;

    x64_bc_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (gnt_onehot[j]) begin
                sel_a = data_a[OP_W*j +: OP_W];
                sel_b = data_b[OP_W*j +: OP_W];
            end
        end
    end

    assign is_last = (cnt_q == CNT_W'(FRAME_BYTES - 1));

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        src_id_d     = src_id_q;
        ack_d        = '0;
`ifdef BC_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    shift_d      = {sel_b, sel_a};
                    ack_d        = gnt_onehot;
                    src_id_d     = gnt_idx;
                    last_grant_d = gnt_idx;
                    cnt_d        = '0;
`ifdef BC_CHECKSUM_EN
                    csum_d       = '0;
`endif
                    state_d      = StXfer;
                end
            end
            StXfer: begin
                if (byte_ready) begin
                    shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
`ifdef BC_CHECKSUM_EN
                    if (!is_last) begin
                        csum_d = csum_q ^ shift_q[SHIFT_W-1 -: BYTE_W];
                    end
`endif
                    // Counter parks on the last index so it never wraps inside a frame
                    if (is_last) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            cnt_q        <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            src_id_q     <= '0;
            ack_q        <= '0;
`ifdef BC_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            src_id_q     <= src_id_d;
            ack_q        <= ack_d;
`ifdef BC_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    always_comb begin
        byte_o = '0;
        if (state_q == StXfer) begin
            byte_o = shift_q[SHIFT_W-1 -: BYTE_W];
`ifdef BC_CHECKSUM_EN
            if (is_last) begin
                byte_o = csum_q;
            end
`endif
        end
    end

    assign byte_valid = (state_q == StXfer);
    assign byte_last  = (state_q == StXfer) && is_last;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign ack        = ack_q;
    assign src_id     = src_id_q;

endmodule

// File: tb/tb_x64_bc_sched.sv
// Scoreboard bench for x64_bc_sched: directed frames plus randomized requesters.
module tb_x64_bc_sched;

    localparam int NREQ = 2;
    localparam int IDW  = 3;
`ifdef BC_CHECKSUM_EN
    localparam int FB = 17;
`else
    localparam int FB = 16;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [64*NREQ-1:0]   data_a, data_b;
    logic [NREQ-1:0]      ack;
    logic [7:0]           byte_o;
    logic                 byte_valid;
    logic                 byte_ready = 1'b0;
    logic                 byte_last;
    logic [IDW-1:0]       src_id;
    logic                 busy;
    logic                 done;

    logic [63:0] da [NREQ];
    logic [63:0] db [NREQ];

    always_comb begin
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            data_a[64*i +: 64] = da[i];
            data_b[64*i +: 64] = db[i];
        end
    end

    x64_bc_sched #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_a     (data_a),
        .data_b     (data_b),
        .ack        (ack),
        .byte_o     (byte_o),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .src_id     (src_id),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [7:0] b;
        logic       last;
        int         id;
    } exp_t;

    exp_t        q[$];
    int          phase    = 0;  // 0 free, 1 frame bytes, 2 expect done, 3 gap cycle
    int          lg       = NREQ - 1;
    int          frame_acc = 0;
    int          accepted = 0;

    logic [NREQ-1:0] req_e = '0;
    logic            rst_e = 1'b0;
    logic [63:0]     da_e [NREQ];
    logic [63:0]     db_e [NREQ];

    function automatic int rr_pick(logic [NREQ-1:0] r, int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic push_frame(int g);
        logic [127:0] v;
        logic [7:0]   x;
        exp_t         e;
        v = {db_e[g], da_e[g]};
        x = 8'h00;
        for (int n = 0; n < 16; n++) begin
            e.b    = 8'((v >> (120 - 8 * n)) & 128'hff);
            e.last = (n == FB - 1);
            e.id   = g;
            x      = x ^ e.b;
            q.push_back(e);
        end
        if (FB == 17) begin
            e.b    = x;
            e.last = 1'b1;
            e.id   = g;
            q.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        req_e <= req;
        rst_e <= rst;
        for (int i = 0; i < NREQ; i++) begin
            da_e[i] <= da[i];
            db_e[i] <= db[i];
        end
    end

    always @(negedge clk) begin
        int   g;
        exp_t e;
        if (!rst) begin
            q.delete();
            phase     = 0;
            lg        = NREQ - 1;
            frame_acc = 0;
        end else if (phase == 3) begin
            chk("gap_ack", ack, 0);
            chk("gap_done", done, 0);
            phase = 0;
        end else if (phase == 2) begin
            chk("done_pulse", done, 1);
            chk("done_valid_low", byte_valid, 0);
            chk("done_ack", ack, 0);
            phase = 3;
        end else begin
            if (phase == 0) begin
                g = rst_e ? rr_pick(req_e, lg) : -1;
                if (g < 0) begin
                    chk("idle_ack", ack, 0);
                    chk("idle_valid", byte_valid, 0);
                end else begin
                    chk("ack_grant", ack, 64'(1) << g);
                    chk("ack_src_id", src_id, g);
                    lg = g;
                    push_frame(g);
                    frame_acc = 0;
                    phase = 1;
                end
            end else begin
                chk("busy_ack", ack, 0);
            end
            if (phase == 1) begin
                e = q[0];
                chk("byte_valid", byte_valid, 1);
                chk("byte_o", byte_o, e.b);
                chk("byte_last", byte_last, e.last);
                chk("src_id", src_id, e.id);
                chk("busy", busy, 1);
                chk("xfer_done", done, 0);
                if (byte_ready) begin
                    void'(q.pop_front());
                    frame_acc++;
                    accepted++;
                    if (e.last) phase = 2;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(int i);
        for (int c = 0; c < 300; c++) begin
            tick();
            if (ack[i]) return;
        end
        fail_now("ack_wait");
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 600; c++) begin
            tick();
            if (phase == 0 && q.size() == 0) return;
        end
        fail_now("idle_wait");
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_valid"}, byte_valid, 0);
        chk({tag, "_last"}, byte_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_src_id"}, src_id, 0);
        chk({tag, "_byte_o"}, byte_o, 0);
    endtask

    task automatic do_reset();
        req = '0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst");
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic send_one(int i, logic [63:0] a, logic [63:0] b);
        da[i]  = a;
        db[i]  = b;
        req[i] = 1'b1;
        wait_ack(i);
        req[i] = 1'b0;
        wait_idle();
    endtask

    initial begin
        int acc0;
        int n;
        int order[$];
        int exp_order[3];
        bit started;
        bit pat[4];

        for (int i = 0; i < NREQ; i++) begin
            da[i] = '0;
            db[i] = '0;
        end
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("por");
        tick();
        tick();
        rst = 1'b1;
        byte_ready = 1'b1;

        // single directed frame from requester 0
        acc0 = accepted;
        send_one(0, 64'h0011223344556677, 64'h8899AABBCCDDEEFF);
        chk("frame1_count", accepted - acc0, FB);

        // both requesting for three frames: rotation 0,1,0 after reset
        do_reset();
        da[0] = {$urandom, $urandom};
        db[0] = {$urandom, $urandom};
        da[1] = {$urandom, $urandom};
        db[1] = {$urandom, $urandom};
        req = 2'b11;
        n = 0;
        for (int c = 0; c < 300 && n < 3; c++) begin
            tick();
            if (ack != 0) begin
                order.push_back(ack[1] ? 1 : 0);
                n++;
                if (n == 3) req = '0;
            end
        end
        if (n < 3) begin
            req = '0;
            fail_now("rotation_acks");
        end
        wait_idle();
        exp_order = '{0, 1, 0};
        for (int k = 0; k < order.size() && k < 3; k++) begin
            chk("rotation_order", order[k], exp_order[k]);
        end

        // backpressure pattern 1,0,0,1
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        acc0 = accepted;
        started = 1'b0;
        da[0] = {$urandom, $urandom};
        db[0] = {$urandom, $urandom};
        req[0] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (ack[0]) begin
                req[0]  = 1'b0;
                started = 1'b1;
            end
            byte_ready = pat[c % 4];
            if (started && phase == 0 && q.size() == 0) break;
        end
        byte_ready = 1'b1;
        wait_idle();
        chk("backpressure_count", accepted - acc0, FB);

        // reset after five bytes of a frame, then requester 1 restarts cleanly
        da[0] = {$urandom, $urandom};
        db[0] = {$urandom, $urandom};
        req[0] = 1'b1;
        wait_ack(0);
        req[0] = 1'b0;
        for (int c = 0; c < 100 && frame_acc < 5; c++) tick();
        chk("mid_frame_busy", busy, 1);
        do_reset();
        acc0 = accepted;
        send_one(1, {$urandom, $urandom}, {$urandom, $urandom});
        chk("post_reset_count", accepted - acc0, FB);

        // one-cycle req[1] pulse while busy must be dropped
        da[0] = {$urandom, $urandom};
        db[0] = {$urandom, $urandom};
        req[0] = 1'b1;
        wait_ack(0);
        req[0] = 1'b0;
        tick();
        tick();
        da[1]  = {$urandom, $urandom};
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        wait_idle();
        repeat (6) tick();

        // frame whose checksum byte is 8'hFF
        send_one(0, 64'h0, 64'h0102040810204080);

        // randomized requesters and backpressure
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        da[i] = {$urandom, $urandom};
                        db[i] = {$urandom, $urandom};
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    da[i]  = {$urandom, $urandom};
                    db[i]  = {$urandom, $urandom};
                    req[i] = 1'b1;
                end
            end
            byte_ready = ($urandom_range(3, 0) != 0);
        end
        req = '0;
        byte_ready = 1'b1;
        wait_idle();
        repeat (4) tick();
        chk("scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/x64_bc_sched.md
Name: x64_bc_sched

Overview:
- Round-robin arbiter and sequencer for the 128-bit to byte serializer path of the div64 result stream.
- Up to NREQ producers (divider lanes) each present a 64-bit operand pair {b,a}.
- The block grants one producer and captures its pair.
- It emits 16 bytes, MSB of b first, over a valid/ready byte port, then pulses done and re-arbitrates.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of src_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request, level; held until ack.
- data_a  input  64*NREQ  operand a of requester i at bits [64i+63:64i].
- data_b  input  64*NREQ  operand b of requester i, same packing.
- ack  output  NREQ  one-cycle pulse: requester i's pair captured.
- byte_o  output  8  current serialized byte.
- byte_valid  output  1  byte_o is valid.
- byte_ready  input  1  downstream accepts byte_o this cycle.
- byte_last  output  1  current byte is the final byte of the frame.
- src_id  output  IDW  index of the requester owning the current frame.
- busy  output  1  high in XFER and DONE.
- done  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; ack=0, byte_valid=0, byte_last=0, done=0, busy=0, src_id=0, byte_o=0, shift=0, byte_cnt=0; last_grant=NREQ-1, so requester 0 wins first.
- States: IDLE, XFER, DONE.
- IDLE, req==0: hold.
- IDLE, any req set:
  - g = first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - At the edge: shift<={data_b[g],data_a[g]}, ack[g]<=1 for exactly one cycle, src_id<=g, last_grant<=g, byte_cnt<=0, state<=XFER.
  - Latency from req sampled to first byte_valid: 1 cycle.
- XFER:
  - byte_valid=1 and byte_o=shift[127:120], both registered-state driven with no combinational path from req or data.
  - byte_last=1 when byte_cnt==15.
  - On byte_valid&&byte_ready: shift<={shift[119:0],8'h00}, byte_cnt<=byte_cnt+1.
  - If the accepted byte was last, state<=DONE.
  - With byte_ready=0: byte_o, byte_cnt and byte_last hold indefinitely.
- DONE: byte_valid=0, done=1 for one cycle, then state<=IDLE. Arbitration resumes the following cycle, giving 1 idle cycle minimum between frames.
- Requests and data are ignored outside IDLE. A requester whose req drops before being granted gets no ack. A requester must hold data_a/data_b stable until its ack cycle.
- Simultaneous requests: only the granted index is acked; others keep waiting and are served in rotation order.
- With all requesters continuously active, each frame of every requester is served within NREQ frames.
- Byte order per frame: b[63:56] … b[7:0], a[63:56] … a[7:0].
- byte_cnt is 4 bits, or 5 bits with the optional feature; it never wraps within a frame.
- Reset mid-frame aborts the frame with no done; the partial frame is never resumed.

Optional Feature:
- Macro: BC_CHECKSUM_EN.
- When defined:
  - Each frame is 17 bytes.
  - Byte 17 is the XOR of the 16 data bytes, accumulated on each accepted byte and cleared at capture.
  - byte_last asserts on byte 17 (byte_cnt==16) instead of byte 16.
  - done follows acceptance of byte 17.
- When undefined: 16-byte frames, no checksum logic.

Decomposition:
- Package x64_bc_pkg:
  - State enum (IDLE, XFER, DONE).
  - FRAME_BYTES constant (16, or 17 under BC_CHECKSUM_EN).
  - Operand width 64 and byte width 8 constants.
- Sub-module x64_bc_rr_arb holds the round-robin arbiter. It is combinational grant from req and last_grant, plus a one-hot/index output.
- Shift register, counter and FSM stay in the top module.

Test Plan:
- Reset then req=2'b01, a=64'h0011223344556677, b=64'h8899AABBCCDDEEFF, byte_ready=1 -> ack[0] pulse, then bytes 88,99,AA,BB,CC,DD,EE,FF,00,11,22,33,44,55,66,77 on consecutive cycles, byte_last on 77, done 1 cycle later, src_id=0.
- req=2'b11 held for three frames -> grants in order 0,1,0, each with matching ack pulse and src_id.
- Frame in progress with byte_ready toggled 1,0,0,1 pattern -> each byte is held while ready=0, no byte is dropped or duplicated, and exactly 16 bytes are accepted.
- Assert rst=0 after byte 5 of a frame -> all outputs return to reset values asynchronously. The next req=2'b10 is granted to requester 1, and the frame restarts at its byte 0.
- req[1] pulsed high for one cycle while busy -> no ack[1], no frame for requester 1.
- BC_CHECKSUM_EN with a=0, b=64'h0102040810204080 -> 17th byte 8'hFF with byte_last, done after its acceptance.
